spi_flash_responder: RTL
========================

// Module: spi_flash_responder
// PURPOSE
//  SPI mode-0 responder (target) emulating a read-only subset of a serial NOR flash: READ,
//  FAST_READ, JEDEC ID, READ STATUS and RELEASE POWER-DOWN.
//  Sits on the opposite end of the bootloader's spi_sck/spi_so/spi_si/spi_ss master link.
//  Serves images from an on-chip memory port, so the bootloader can be exercised without
//  external flash (lab loopback and simulation).
//  Oversampled: SCK, SS and MOSI are synchronised into clk; max SCK = clk/8.
// PARAMETERS
//  ADDR_W    24         memory address width; stream address wraps modulo 2**ADDR_W
//  JEDEC_ID  24'hEF4016 3-byte manufacturer/type/capacity returned by 0x9F, MSB first
//  STATUS    8'h00      byte returned by 0x05 (BUSY=0, WEL=0)
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous reset, active-high
//  spi_sck      in   1      SPI clock from master, async
//  spi_ss       in   1      chip select, active-low, async
//  spi_si       in   1      MOSI (master's spi_so), async
//  spi_so       out  1      MISO (master's spi_si)
//  spi_so_oe    out  1      MISO output enable; 1 only while selected and driving
//  mem_addr     out  ADDR_W read address to memory
//  mem_rd_en    out  1      one-cycle read strobe
//  mem_rd_data  in   8      read data, valid exactly one clk after mem_rd_en
//  active       out  1      1 while SS is low (synchronised)
// BEHAVIOUR
//  - Reset: spi_so=0, spi_so_oe=0, mem_addr=0, mem_rd_en=0, active=0, state=IDLE.
//  - Input sync: 2-FF synchroniser on sck, ss, si, plus a third stage for edge detection.
//    rise = sck 0->1 and ss low; fall = sck 1->0 and ss low. MOSI is sampled on rise.
//  - Bit order: MSB first. Bit counter 0..7; a byte completes on the 8th rise.
//  - FSM
//    IDLE  : ss low -> CMD, clear counters.
//    CMD   : on byte complete decode:
//            03 -> ADDR(dummy=0); 0B -> ADDR(dummy=1); 9F -> DATA(src=ID);
//            05 -> DATA(src=STATUS); AB -> IGNORE (accepted, no output); other -> IGNORE.
//    ADDR  : shift 24 bits and keep the low ADDR_W. On the 24th rise go to DUMMY if
//            dummy=1, else DATA(src=MEM) and pulse mem_rd_en with mem_addr=address.
//    DUMMY : 8 rises ignored, then DATA(src=MEM) plus read strobe.
//    DATA  : shift register loaded with the next byte. Its MSB drives spi_so on the first
//            fall after entry; each later fall shifts. On the fall that emits bit 0 of a
//            MEM byte, increment mem_addr (wrap at 2**ADDR_W) and strobe mem_rd_en so the
//            next byte is ready for the following byte's first fall.
//            ID stream repeats JEDEC_ID bytes 0,1,2,0,...; STATUS repeats STATUS.
//    IGNORE: spi_so_oe=0 until deselect.
//  - Any state: synchronised ss high -> IDLE next clk; spi_so_oe=0, spi_so=0, partial byte
//    discarded, mem_addr retained. Deselect mid-byte is legal and produces no side effect.
//  - spi_so_oe=1 only in DATA, from the first fall until deselect.
//  - rise and fall in the same clk cannot occur (edge detect is a single stage); ss rising
//    in the same clk as a sck edge: deselect wins.
//  - Latency: CS-low to first command-bit capture is <=3 clk; the read strobe fires 1 clk
//    after the 24th/dummy rise; data is loaded 1 clk after the strobe, <=3 clk before the
//    next fall at SCK=clk/8.
//  - rst asserted mid-transaction: immediate return to reset values. The master must
//    deselect before the responder answers again; it stays IDLE until ss is seen high.
// STRUCTURE
//  - Shared package: opcode constants (CMD_READ=8'h03, CMD_FAST_READ=8'h0B,
//    CMD_JEDEC_ID=8'h9F, CMD_READ_STATUS=8'h05, CMD_WAKE=8'hAB) and the state encoding.
//    Also used by the bootloader's SPI master.
//  - One sub-module: spi_edge_sync (2-FF sync + edge detect for sck/ss/si;
//    outputs rise, fall, ss_n_s, si_s).
//  - Remainder (FSM, shift registers, address counter) lives in this file.
// TESTING
//  - 9F at SCK=clk/8 with 4 read bytes -> MISO EF 40 16 EF; oe=0 during the opcode byte.
//  - 03 000010, 3 bytes, mem[10..12]=A5 5A C3 -> A5 5A C3; mem_rd_en pulses at 0x10, 0x11, 0x12.
//  - 0B 000000 + dummy, 2 bytes -> mem[0], mem[1]; no mem_rd_en during the dummy byte.
//  - 03 FFFFFF (ADDR_W=24), 2 bytes -> mem[FFFFFF], mem[000000] (wrap).
//  - 03 then ss high after 12 addr bits, then 05 -> 00; oe=0 between; no mem_rd_en.
//  - Opcode 0x42 + 3 clocked bytes -> oe stays 0; rst pulse during a READ data byte ->
//    outputs 0 next clk; no response until a fresh ss low.

Source files
------------

// File: rtl/spi_flash_responder_pkg.sv
// Opcodes, FSM encoding and stream-source selectors shared by the SPI flash responder
// and the bootloader's SPI master.
package spi_flash_responder_pkg;

  localparam logic [7:0] CMD_READ        = 8'h03;
  localparam logic [7:0] CMD_FAST_READ   = 8'h0B;
  localparam logic [7:0] CMD_JEDEC_ID    = 8'h9F;
  localparam logic [7:0] CMD_READ_STATUS = 8'h05;
  localparam logic [7:0] CMD_WAKE        = 8'hAB;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DUMMY  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  localparam logic [1:0] SRC_MEM    = 2'd0;
  localparam logic [1:0] SRC_ID     = 2'd1;
  localparam logic [1:0] SRC_STATUS = 2'd2;

  // Byte idx of a 3-byte JEDEC ID, MSB (manufacturer) first.
  function automatic logic [7:0] jedec_byte(input logic [23:0] id, input logic [1:0] idx);
    case (idx)
      2'd0:    return id[23:16];
      2'd1:    return id[15:8];
      default: return id[7:0];
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_responder_edge_sync.sv
// Two-flop synchronisers for SCK/SS/MOSI plus SCK edge detect; edges are 3 clk behind the pins.
// Edges are gated by synchronised SS so a deselected bus never produces activity.
module spi_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic spi_sck,
  input  logic spi_ss,
  input  logic spi_si,
  output logic rise,
  output logic fall,
  output logic ss_n_s,
  output logic si_s
);

  logic [2:0] sck_q;
  logic [1:0] ss_q;
  logic [1:0] si_q;

  // SS resets to "selected" so that only a genuinely observed high can re-arm the responder.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q <= '0;
      ss_q  <= '0;
      si_q  <= '0;
    end else begin
      sck_q <= {sck_q[1:0], spi_sck};
      ss_q  <= {ss_q[0], spi_ss};
      si_q  <= {si_q[0], spi_si};
    end
  end

  assign ss_n_s = ss_q[1];
  assign si_s   = si_q[1];
  assign rise   = sck_q[1] & ~sck_q[2] & ~ss_q[1];
  assign fall   = ~sck_q[1] & sck_q[2] & ~ss_q[1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 read-only NOR flash emulator (READ, FAST_READ, JEDEC ID, STATUS, WAKE) backed by a
// 1-cycle-latency memory port; MISO bits appear ~3 clk after each SCK fall, no flow control.
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter int unsigned ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016,
  parameter logic [7:0]  STATUS   = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_ss,
  input  logic              spi_si,
  output logic              spi_so,
  output logic              spi_so_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rd_data,
  output logic              active
);

  logic rise, fall, ss_n_s, si_s;

  spi_edge_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .spi_sck (spi_sck),
    .spi_ss  (spi_ss),
    .spi_si  (spi_si),
    .rise    (rise),
    .fall    (fall),
    .ss_n_s  (ss_n_s),
    .si_s    (si_s)
  );

  logic [2:0]        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [22:0]       sh_q, sh_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dummy_q, dummy_d;
  logic [1:0]        src_q, src_d;
  logic [1:0]        id_idx_q, id_idx_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        out_sh_q, out_sh_d;
  logic              so_q, so_d, oe_q, oe_d;
  logic              rd_en_q, rd_en_d, rd_pend_q, rd_pend_d;
  logic              armed_q, armed_d;
  logic [23:0]       addr_full;
  logic [7:0]        cmd_byte;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    dummy_d   = dummy_q;
    src_d     = src_q;
    id_idx_d  = id_idx_q;
    tx_d      = tx_q;
    out_sh_d  = out_sh_q;
    so_d      = so_q;
    oe_d      = oe_q;
    rd_en_d   = 1'b0;
    rd_pend_d = rd_en_q;
    armed_d   = armed_q | ss_n_s;
    addr_full = {sh_q, si_s};
    cmd_byte  = {sh_q[6:0], si_s};

    // Memory answers one clk after the strobe; park the byte until its first fall.
    if (rd_pend_q && src_q == SRC_MEM) tx_d = mem_rd_data;

    if (ss_n_s) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      so_d    = 1'b0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (armed_q) begin
            state_d = ST_CMD;
            cnt_d   = '0;
          end
        end
        ST_CMD: begin
          if (rise) begin
            sh_d  = {sh_q[21:0], si_s};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d = '0;
              case (cmd_byte)
                CMD_READ:      begin state_d = ST_ADDR; dummy_d = 1'b0; end
                CMD_FAST_READ: begin state_d = ST_ADDR; dummy_d = 1'b1; end
                CMD_JEDEC_ID: begin
                  state_d  = ST_DATA;
                  src_d    = SRC_ID;
                  tx_d     = jedec_byte(JEDEC_ID, 2'd0);
                  id_idx_d = 2'd1;
                end
                CMD_READ_STATUS: begin
                  state_d = ST_DATA;
                  src_d   = SRC_STATUS;
                  tx_d    = STATUS;
                end
                CMD_WAKE: state_d = ST_IGNORE;
                default:  state_d = ST_IGNORE;
              endcase
            end
          end
        end
        ST_ADDR: begin
          if (rise) begin
            sh_d  = {sh_q[21:0], si_s};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
              cnt_d  = '0;
              addr_d = addr_full[ADDR_W-1:0];
              if (dummy_q) begin
                state_d = ST_DUMMY;
              end else begin
                state_d = ST_DATA;
                src_d   = SRC_MEM;
                rd_en_d = 1'b1;
              end
            end
          end
        end
        ST_DUMMY: begin
          if (rise) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d   = '0;
              state_d = ST_DATA;
              src_d   = SRC_MEM;
              rd_en_d = 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (fall) begin
            oe_d = 1'b1;
            if (cnt_q[2:0] == 3'd0) begin
              so_d     = tx_q[7];
              out_sh_d = {tx_q[6:0], 1'b0};
            end else begin
              so_d     = out_sh_q[7];
              out_sh_d = {out_sh_q[6:0], 1'b0};
            end
            cnt_d = {2'b00, cnt_q[2:0] + 3'd1};
            // Emitting bit 0: fetch the following byte now so it is ready for its first fall.
            if (cnt_q[2:0] == 3'd7) begin
              case (src_q)
                SRC_MEM: begin
                  addr_d  = addr_q + 1'b1;
                  rd_en_d = 1'b1;
                end
                SRC_ID: begin
                  tx_d     = jedec_byte(JEDEC_ID, id_idx_q);
                  id_idx_d = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
                end
                default: tx_d = STATUS;
              endcase
            end
          end
        end
        ST_IGNORE: state_d = ST_IGNORE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      addr_q    <= '0;
      dummy_q   <= 1'b0;
      src_q     <= SRC_MEM;
      id_idx_q  <= '0;
      tx_q      <= '0;
      out_sh_q  <= '0;
      so_q      <= 1'b0;
      oe_q      <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      addr_q    <= addr_d;
      dummy_q   <= dummy_d;
      src_q     <= src_d;
      id_idx_q  <= id_idx_d;
      tx_q      <= tx_d;
      out_sh_q  <= out_sh_d;
      so_q      <= so_d;
      oe_q      <= oe_d;
      rd_en_q   <= rd_en_d;
      rd_pend_q <= rd_pend_d;
      armed_q   <= armed_d;
    end
  end

  assign spi_so    = so_q;
  assign spi_so_oe = oe_q;
  assign mem_addr  = addr_q;
  assign mem_rd_en = rd_en_q;
  assign active    = armed_q & ~ss_n_s;

endmodule
